maxpool2d_backward: RTL and testbench

//  Backward (gradient-routing) pass of 2D max-pooling for on-chip training.

---
 rtl/maxpool2d_backward_pkg.sv | 21 ++
 rtl/maxpool2d_backward_if.sv | 22 ++
 rtl/maxpool2d_backward_lane.sv | 33 +++
 rtl/maxpool2d_backward.sv | 161 ++++++++++++++++
 tb/tb_maxpool2d_backward.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/maxpool2d_backward_pkg.sv
// Shared types and constants for the max-pool backward (gradient routing) block.
package maxpool_pkg;

    typedef logic signed [31:0] q16_16_t;

    localparam q16_16_t MOST_NEG = 32'sh8000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SCAN  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } bp_state_t;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool2d_backward_if.sv
// Run handshake plus flat activation/gradient buses of the max-pool backward block.
interface maxpool2d_backward_if #(
    parameter int IN_N  = 2704,
    parameter int OUT_N = 676
);
    logic                                start;
    maxpool_pkg::q16_16_t [IN_N-1:0]     act_in;
    maxpool_pkg::q16_16_t [OUT_N-1:0]    grad_out;
    maxpool_pkg::q16_16_t [IN_N-1:0]     grad_in;
    logic                                busy;
    logic                                done;

    modport master (
        output start, act_in, grad_out,
        input  grad_in, busy, done
    );

    modport slave (
        input  start, act_in, grad_out,
        output grad_in, busy, done
    );
endinterface

// File: rtl/maxpool2d_backward_lane.sv
// One channel's running argmax over a pooling window; ties keep the earliest index.
module pool_argmax_lane
    import maxpool_pkg::*;
#(
    parameter int W  = 32,
    parameter int KW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                first,
    input  logic                valid,
    input  logic signed [W-1:0] value,
    input  logic [KW-1:0]       k,
    output logic [KW-1:0]       best_k
);

    logic signed [W-1:0] best_val_r;
    logic [KW-1:0]       best_k_r;

    // Strictly-greater replacement makes ties resolve to the lowest k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val_r <= W'(MOST_NEG);
            best_k_r   <= '0;
        end else if (valid && (first || (value > best_val_r))) begin
            best_val_r <= value;
            best_k_r   <= k;
        end
    end

    assign best_k = best_k_r;

endmodule

// File: rtl/maxpool2d_backward.sv
// Max-pool backward pass: re-derives each window's argmax from the forward input and
// routes the upstream gradient there, all channels in parallel, outputs scanned row-major.
module maxpool2d_backward
    import maxpool_pkg::*;
#(
    parameter int IN_H     = 26,
    parameter int IN_W     = 26,
    parameter int CHANNELS = 4,
    parameter int POOL_H   = 2,
    parameter int POOL_W   = 2,
    parameter int BITS     = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    maxpool2d_backward_if.slave  bus
);

    localparam int OUT_H  = IN_H / POOL_H;
    localparam int OUT_W  = IN_W / POOL_W;
    localparam int PLANE  = IN_H * IN_W;
    localparam int OUT_HW = OUT_H * OUT_W;
    localparam int IN_N   = PLANE * CHANNELS;
    localparam int OUT_N  = OUT_HW * CHANNELS;
    localparam int POOL_N = POOL_H * POOL_W;
    localparam int AW     = idx_w(IN_N);
    localparam int OAW    = idx_w(OUT_N);
    localparam int KW     = idx_w(POOL_N);
    localparam int PRW    = idx_w(POOL_H);
    localparam int PCW    = idx_w(POOL_W);
    localparam int ORW    = idx_w(OUT_H);
    localparam int OCW    = idx_w(OUT_W);
    localparam int POSW   = idx_w(OUT_HW);

    bp_state_t              state;
    logic [POSW-1:0]        pos;
    logic [ORW-1:0]         orow;
    logic [OCW-1:0]         ocol;
    logic [PRW-1:0]         pr;
    logic [PCW-1:0]         pc;
    logic                   busy_r;
    logic                   done_r;
    logic [IN_N-1:0][BITS:0] grad_in_r;

    logic                   first_s;
    logic                   valid_s;
    logic [KW-1:0]          k_s;
    logic [KW-1:0]          best_k_s  [CHANNELS];
    logic [AW-1:0]          rd_addr_s [CHANNELS];
    logic [AW-1:0]          wr_addr_s [CHANNELS];
    logic [OAW-1:0]         go_addr_s [CHANNELS];

    // Window element being scanned and where each channel's winner lands.
    always_comb begin
        first_s = (pr == '0) && (pc == '0);
        valid_s = (state == SCAN);
        k_s     = KW'(int'(pr) * POOL_W + int'(pc));
        for (int g = 0; g < CHANNELS; g++) begin
            rd_addr_s[g] = AW'(g * PLANE + (int'(orow) * POOL_H + int'(pr)) * IN_W
                               + int'(ocol) * POOL_W + int'(pc));
            wr_addr_s[g] = AW'(g * PLANE
                               + (int'(orow) * POOL_H + int'(best_k_s[g]) / POOL_W) * IN_W
                               + int'(ocol) * POOL_W + int'(best_k_s[g]) % POOL_W);
            go_addr_s[g] = OAW'(g * OUT_HW + int'(pos));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_lane
        pool_argmax_lane #(
            .W  (BITS + 1),
            .KW (KW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .first  (first_s),
            .valid  (valid_s),
            .value  (bus.act_in[rd_addr_s[g]]),
            .k      (k_s),
            .best_k (best_k_s[g])
        );
    end

    // Run sequencer: clear, scan each window, write the winner, repeat until the last output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= '0;
            orow      <= '0;
            ocol      <= '0;
            pr        <= '0;
            pc        <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            grad_in_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= CLEAR;
                        busy_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    grad_in_r <= '0;
                    pos       <= '0;
                    orow      <= '0;
                    ocol      <= '0;
                    pr        <= '0;
                    pc        <= '0;
                    state     <= SCAN;
                end
                SCAN: begin
                    if (pc == PCW'(POOL_W - 1)) begin
                        pc <= '0;
                        if (pr == PRW'(POOL_H - 1)) begin
                            pr    <= '0;
                            state <= WRITE;
                        end else begin
                            pr <= pr + 1'b1;
                        end
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                WRITE: begin
                    for (int g = 0; g < CHANNELS; g++) begin
                        grad_in_r[wr_addr_s[g]] <= bus.grad_out[go_addr_s[g]];
                    end
                    if (pos == POSW'(OUT_HW - 1)) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        pos   <= pos + 1'b1;
                        state <= SCAN;
                        if (ocol == OCW'(OUT_W - 1)) begin
                            ocol <= '0;
                            orow <= orow + 1'b1;
                        end else begin
                            ocol <= ocol + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grad_in = grad_in_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_maxpool2d_backward.sv
// Scoreboard bench for maxpool2d_backward on a 5x5x2 input with 2x2 pooling.
`timescale 1ns/1ps
module tb_maxpool2d_backward;

    localparam int IH = 5, IW = 5, CH = 2, PH = 2, PW = 2;
    localparam int OH = IH / PH, OW = IW / PW;
    localparam int PLANE = IH * IW, OHW = OH * OW;
    localparam int IN_N = PLANE * CH, OUT_N = OHW * CH;
    localparam int LAT = 1 + OHW * (PH * PW + 1);

    typedef logic [IN_N-1:0][31:0]  avec_t;
    typedef logic [OUT_N-1:0][31:0] ovec_t;
    typedef struct packed {
        logic [31:0] done_cyc;
        avec_t       g;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    avec_t       act;
    ovec_t       gout;
    exp_t        exp_q[$];

    maxpool2d_backward_if #(.IN_N(IN_N), .OUT_N(OUT_N)) bus ();

    maxpool2d_backward #(
        .IN_H(IH), .IN_W(IW), .CHANNELS(CH), .POOL_H(PH), .POOL_W(PW), .BITS(31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    task automatic check_vec(input string name, input avec_t got, input avec_t want);
        int bad;
        bad = -1;
        n_checks++;
        for (int i = IN_N - 1; i >= 0; i--) if (got[i] !== want[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: grad_in[%0d] got 0x%08h, expected 0x%08h",
                     name, bad, got[bad], want[bad]);
        end
    endtask

    function automatic int win_addr(input int ch, input int orow, input int ocol, input int k);
        return ch * PLANE + (orow * PH + k / PW) * IW + ocol * PW + k % PW;
    endfunction

    // Reference: window maximum (signed), first position holding it gets the gradient.
    function automatic avec_t model(input avec_t a, input ovec_t go);
        avec_t r;
        int    mx, bk;
        r = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int orow = 0; orow < OH; orow++)
                for (int ocol = 0; ocol < OW; ocol++) begin
                    mx = $signed(a[win_addr(ch, orow, ocol, 0)]);
                    for (int k = 1; k < PH * PW; k++)
                        if ($signed(a[win_addr(ch, orow, ocol, k)]) > mx)
                            mx = $signed(a[win_addr(ch, orow, ocol, k)]);
                    bk = 0;
                    for (int k = PH * PW - 1; k >= 0; k--)
                        if ($signed(a[win_addr(ch, orow, ocol, k)]) == mx) bk = k;
                    r[win_addr(ch, orow, ocol, bk)] = go[ch * OHW + orow * OW + ocol];
                end
        return r;
    endfunction

    task automatic set_win(input int ch, input int orow, input int ocol,
                           input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
        logic [3:0][31:0] v;
        v = {v3, v2, v1, v0};
        for (int k = 0; k < 4; k++) act[win_addr(ch, orow, ocol, k)] = v[k];
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < IN_N; i++) begin
            case ($urandom_range(0, 2))
                0:       act[i] = $urandom();
                1:       act[i] = $urandom_range(0, 3);
                default: act[i] = 32'h8000_0000 + $urandom_range(0, 3);
            endcase
        end
        for (int j = 0; j < OUT_N; j++) gout[j] = $urandom() | 32'h0000_0001;
    endtask

    task automatic push_run(input int unsigned start_edge);
        exp_t e;
        e.done_cyc = start_edge + LAT;
        e.g        = model(act, gout);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_once();
        @(negedge clk);
        bus.act_in   = act;
        bus.grad_out = gout;
        push_run(cyc + 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
    endtask

    task automatic wait_cycle(input string name, input int unsigned target);
        for (int i = 0; i < 200 && cyc != target; i++) @(negedge clk);
        check(name, cyc, target);
    endtask

    // Monitor: every done pulse must match the oldest expected run.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done) begin
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done_latency", cyc, e.done_cyc);
                check("busy_at_done", 32'(bus.busy), 32'd1);
                check_vec("grad_in", bus.grad_in, e.g);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int unsigned s;
        logic [31:0] rem;
        bus.start    = 1'b0;
        act          = '0;
        gout         = '0;
        bus.act_in   = act;
        bus.grad_out = gout;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check_vec("reset_grad_in", bus.grad_in, '0);
        rst = 1'b0;

        // Basic routing, latency 21.
        randomize_inputs();
        set_win(0, 0, 0, 32'd1, 32'd5, 32'd3, 32'd2);
        gout[0] = 32'h0001_8000;
        run_once();
        check("t2_argmax", bus.grad_in[1], 32'h0001_8000);
        check("t2_zero0", bus.grad_in[0], 32'd0);
        check("t2_zero5", bus.grad_in[5], 32'd0);
        check("t2_zero6", bus.grad_in[6], 32'd0);

        // Ties and signed negatives.
        randomize_inputs();
        set_win(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        set_win(0, 0, 1, 32'hFFFD_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFF9_0000);
        set_win(0, 1, 1, 32'h8000_0000, 32'hFFFF_0000, 32'h8000_0001, 32'h8000_0000);
        set_win(1, 1, 0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_once();
        check("t3_tie_k0", bus.grad_in[0], gout[0]);
        check("t3_tie_k1_zero", bus.grad_in[1], 32'd0);
        check("t3_neg_tie_k1", bus.grad_in[3], gout[1]);
        check("t3_neg_tie_k2_zero", bus.grad_in[7], 32'd0);
        check("t4_signed_k1", bus.grad_in[13], gout[3]);
        check("t4_signed_ch1", bus.grad_in[PLANE + 11], gout[OHW + 2]);

        // Remainder row/col and independent channels.
        randomize_inputs();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < IW; i++) begin
                act[c * PLANE + 4 * IW + i] = 32'h7FFF_FFFF;
                act[c * PLANE + i * IW + 4] = 32'h7FFF_FFFF;
            end
        set_win(0, 0, 0, 32'd9, 32'd1, 32'd1, 32'd1);
        set_win(1, 0, 0, 32'd1, 32'd1, 32'd1, 32'd9);
        run_once();
        check("t5_ch0_k0", bus.grad_in[0], gout[0]);
        check("t5_ch1_k3", bus.grad_in[PLANE + 6], gout[OHW]);
        check("t5_ch1_k0_zero", bus.grad_in[PLANE], 32'd0);
        rem = '0;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < IW; i++)
                rem = rem | bus.grad_in[c * PLANE + 4 * IW + i] | bus.grad_in[c * PLANE + i * IW + 4];
        check("t5_remainder_zero", rem, 32'd0);

        // Reset mid-scan aborts with no done pulse.
        randomize_inputs();
        @(negedge clk);
        bus.act_in   = act;
        bus.grad_out = gout;
        s = cyc + 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cycle("abort_point", s + 8);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check_vec("abort_grad_in", bus.grad_in, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);

        // Start held high: ignored mid-run, second run after IDLE re-clears.
        randomize_inputs();
        @(negedge clk);
        bus.act_in   = act;
        bus.grad_out = gout;
        s = cyc + 1;
        push_run(s);
        push_run(s + LAT + 2);
        bus.start = 1'b1;
        wait_cycle("second_accept", s + LAT + 2);
        bus.start = 1'b0;
        @(negedge clk);
        check_vec("t6_reclear", bus.grad_in, '0);
        check("t6_busy", 32'(bus.busy), 32'd1);
        wait_drain();

        // Random sweep.
        repeat (8) begin
            randomize_inputs();
            run_once();
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
